// File: rtl/pe_iter.sv
// Iterative processing element: registered GEMM MAC stage plus an N-step unary engine.
// Define PE_ROUND_EN to make sat_trunc round half-up before dropping fraction bits.
module pe_iter #(
    parameter int INT_BW = 5,
    parameter int FRA_BW = 10,
    parameter int MUL_BW = 16,
    parameter int ACC_BW = 32,
    parameter int CNT_BW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode_i,
    input  logic              in_vld_i,
    input  logic [MUL_BW-1:0] x_i,
    input  logic [MUL_BW-1:0] wc_i,
    input  logic [ACC_BW-1:0] o_i,
    input  logic              start_i,
    input  logic [CNT_BW-1:0] iter_i,
    input  logic [ACC_BW-1:0] mac_i,
    input  logic [MUL_BW-1:0] scale_i,
    input  logic [ACC_BW-1:0] offset_i,
    output logic [MUL_BW-1:0] x_o,
    output logic [MUL_BW-1:0] wc_o,
    output logic [ACC_BW-1:0] o_o,
    output logic [ACC_BW-1:0] mac_o,
    output logic              vld_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              sat_o,
    output logic [1:0]        mode_o
);

    // Handshake: start_i is accepted only in IDLE with a non-GEMM mode; busy_o stays
    // high until the one-cycle done_o pulse ends, and no start is taken while busy_o=1.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic signed [ACC_BW:0] SAT_MAX =
        ((ACC_BW+1)'(1) << (INT_BW + 2*FRA_BW)) - ((ACC_BW+1)'(1) << FRA_BW);
    localparam logic signed [ACC_BW:0] SAT_MIN =
        -((ACC_BW+1)'(1) << (INT_BW + 2*FRA_BW));
`ifdef PE_ROUND_EN
    localparam logic signed [ACC_BW:0] RND = (ACC_BW+1)'(1) << (FRA_BW - 1);
`else
    localparam logic signed [ACC_BW:0] RND = '0;
`endif

    state_t                   state;
    logic signed [MUL_BW-1:0] wreg, ireg;
    logic signed [ACC_BW-1:0] oreg;
    logic [CNT_BW-1:0]        cnt;
    logic                     vld_d1, vld_q, sat_q;
    logic [1:0]               mode_q;

    logic signed [ACC_BW:0]     acc_rnd;
    logic signed [MUL_BW-1:0]   acc_t;
    logic                       clip;
    logic signed [2*MUL_BW-1:0] step_prod, gemm_prod;
    logic signed [ACC_BW-1:0]   step_next, gemm_next;
    logic                       start_ok, gemm_en;

    // One extra bit keeps the rounding add from wrapping before the clamp.
    always_comb begin
        acc_rnd = {oreg[ACC_BW-1], oreg} + RND;
        clip    = 1'b0;
        acc_t   = acc_rnd[FRA_BW+MUL_BW-1:FRA_BW];
        if (acc_rnd > SAT_MAX) begin
            acc_t = {1'b0, {(MUL_BW-1){1'b1}}};
            clip  = 1'b1;
        end else if (acc_rnd < SAT_MIN) begin
            acc_t = {1'b1, {(MUL_BW-1){1'b0}}};
            clip  = 1'b1;
        end
    end

    always_comb begin
        step_prod = acc_t * $signed(scale_i);
        step_next = ACC_BW'(step_prod) + $signed(offset_i);
        gemm_prod = wreg * ireg;
        gemm_next = ACC_BW'(gemm_prod) + $signed(o_i);
        start_ok  = (state == IDLE) && start_i && (mode_i != 2'b00);
        gemm_en   = (state == IDLE) && (mode_i == 2'b00) && in_vld_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wreg   <= '0;
            ireg   <= '0;
            oreg   <= '0;
            cnt    <= '0;
            vld_d1 <= 1'b0;
            vld_q  <= 1'b0;
            sat_q  <= 1'b0;
            mode_q <= 2'b00;
        end else begin
            vld_d1 <= gemm_en;
            vld_q  <= (state == IDLE && !start_ok) ? vld_d1 : 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        mode_q <= mode_i;
                        oreg   <= mac_i;
                        cnt    <= iter_i;
                        sat_q  <= 1'b0;
                        state  <= (iter_i == '0) ? DONE : RUN;
                    end else if (gemm_en) begin
                        wreg <= wc_i;
                        ireg <= x_i;
                        oreg <= gemm_next;
                    end
                end
                RUN: begin
                    oreg <= step_next;
                    cnt  <= cnt - CNT_BW'(1);
                    if (clip) sat_q <= 1'b1;
                    if (cnt == CNT_BW'(1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign x_o    = ireg;
    assign wc_o   = wreg;
    assign o_o    = oreg;
    assign mac_o  = oreg;
    assign vld_o  = vld_q;
    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);
    assign sat_o  = sat_q;
    assign mode_o = mode_q;

endmodule

// File: tb/tb_pe_iter.sv
// Directed bench for pe_iter: arithmetic reference model checked every cycle plus literal pins.
module tb_pe_iter;

    logic        clk, rst_n;
    logic [1:0]  mode_i;
    logic        in_vld_i, start_i;
    logic [15:0] x_i, wc_i, scale_i;
    logic [31:0] o_i, mac_i, offset_i;
    logic [3:0]  iter_i;
    logic [15:0] x_o, wc_o;
    logic [31:0] o_o, mac_o;
    logic        vld_o, busy_o, done_o, sat_o;
    logic [1:0]  mode_o;

    int n_tests = 0;
    int n_fail  = 0;

    pe_iter dut (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_i), .in_vld_i(in_vld_i),
        .x_i(x_i), .wc_i(wc_i), .o_i(o_i), .start_i(start_i), .iter_i(iter_i),
        .mac_i(mac_i), .scale_i(scale_i), .offset_i(offset_i),
        .x_o(x_o), .wc_o(wc_o), .o_o(o_o), .mac_o(mac_o), .vld_o(vld_o),
        .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o), .mode_o(mode_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (Q5.10 operands, Q.20 accumulator) ----------------
    function automatic longint rounded(int a);
        longint r;
        r = longint'(a);
`ifdef PE_ROUND_EN
        r = r + 512;
`endif
        return r;
    endfunction

    function automatic bit clip_m(int a);
        return (rounded(a) > 64'sd33553408) || (rounded(a) < -64'sd33554432);
    endfunction

    function automatic int trunc_m(int a);
        if (rounded(a) > 64'sd33553408) return 32767;
        if (rounded(a) < -64'sd33554432) return -32768;
        return int'(rounded(a) >>> 10);
    endfunction

    function automatic logic [31:0] step_m(int a, logic [15:0] s, logic [31:0] off);
        longint p;
        p = longint'(trunc_m(a)) * longint'($signed(s)) + longint'($signed(off));
        return p[31:0];
    endfunction

    function automatic logic [31:0] mac_m(logic [15:0] w, logic [15:0] x, logic [31:0] o);
        longint p;
        p = longint'($signed(w)) * longint'($signed(x)) + longint'($signed(o));
        return p[31:0];
    endfunction

    logic [31:0] m_acc;
    logic [15:0] m_w, m_x;
    logic [1:0]  m_mode;
    bit          m_v1, m_vld, m_busy, m_done, m_sat;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc <= '0; m_w <= '0; m_x <= '0; m_mode <= '0;
            m_v1 <= 0; m_vld <= 0; m_busy <= 0; m_done <= 0; m_sat <= 0; m_left <= 0;
        end else if (m_done) begin
            m_done <= 0; m_busy <= 0; m_v1 <= 0; m_vld <= 0;
        end else if (m_busy) begin
            m_acc  <= step_m(m_acc, scale_i, offset_i);
            if (clip_m(m_acc)) m_sat <= 1;
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1;
            m_v1 <= 0; m_vld <= 0;
        end else if (start_i && mode_i != 2'b00) begin
            m_acc <= mac_i; m_sat <= 0; m_mode <= mode_i; m_busy <= 1;
            m_left <= int'(iter_i);
            m_done <= (iter_i == 0);
            m_v1 <= 0; m_vld <= 0;
        end else begin
            m_vld <= m_v1;
            m_v1  <= in_vld_i && (mode_i == 2'b00);
            if (in_vld_i && mode_i == 2'b00) begin
                m_acc <= mac_m(m_w, m_x, o_i);
                m_w   <= wc_i;
                m_x   <= x_i;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("x_o", 32'(x_o), 32'(m_x));
        chk("wc_o", 32'(wc_o), 32'(m_w));
        chk("o_o", o_o, m_acc);
        chk("mac_o", mac_o, m_acc);
        chk("vld_o", 32'(vld_o), 32'(m_vld));
        chk("busy_o", 32'(busy_o), 32'(m_busy));
        chk("done_o", 32'(done_o), 32'(m_done));
        chk("sat_o", 32'(sat_o), 32'(m_sat));
        chk("mode_o", 32'(mode_o), 32'(m_mode));
    end

    // ---------------- driver helpers ----------------
    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_op(logic [1:0] md, logic [3:0] n, logic [31:0] seed,
                            logic [15:0] sc, logic [31:0] off);
        mode_i = md; start_i = 1'b1; iter_i = n; mac_i = seed; scale_i = sc; offset_i = off;
        cyc(1);
        start_i = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0; mode_i = 2'b00; in_vld_i = 1'b0; start_i = 1'b0;
        x_i = '0; wc_i = '0; o_i = '0; iter_i = '0; mac_i = '0; scale_i = '0; offset_i = '0;
        cyc(3);
        chk("reset_mac", mac_o, 32'h0);
        chk("reset_busy", 32'(busy_o), 32'h0);
        rst_n = 1'b1;
        cyc(1);

        // GEMM: 1.0 * 2.0 + 0x100, partial sum presented alongside the next beat
        mode_i = 2'b00; in_vld_i = 1'b1; wc_i = 16'h0400; x_i = 16'h0800; o_i = 32'h100;
        cyc(1);
        wc_i = 16'h0000; x_i = 16'h0000;
        cyc(1);
        chk("gemm_o", o_o, 32'h0020_0100);
        chk("gemm_model", m_acc, 32'h0020_0100);
        chk("gemm_vld", 32'(vld_o), 32'h1);
        // GEMM with signed operands: -2.0*3.0 then 0.5*0.5
        wc_i = 16'hF800; x_i = 16'h0C00; o_i = 32'h10;
        cyc(1);
        wc_i = 16'h0200; x_i = 16'h0200; o_i = 32'h20;
        cyc(1);
        chk("gemm_neg", o_o, 32'hFFA0_0020);
        wc_i = 16'h0000; x_i = 16'h0000; o_i = 32'h30;
        cyc(1);
        chk("gemm_frac", o_o, 32'h0004_0030);
        in_vld_i = 1'b0;
        cyc(3);
        chk("gemm_hold", o_o, 32'h0004_0030);
        // in_vld with a unary mode but no start, and start with GEMM mode: both ignored
        mode_i = 2'b10; in_vld_i = 1'b1; wc_i = 16'h1234;
        cyc(1);
        mode_i = 2'b00; in_vld_i = 1'b0; start_i = 1'b1; iter_i = 4'd2;
        cyc(1);
        start_i = 1'b0;
        chk("gemm_start_ign", 32'(busy_o), 32'h0);
        cyc(2);

        // Unary N=3, doubling each step, with distractors while busy
        start_op(2'b01, 4'd3, 32'h0010_0000, 16'h0800, 32'h0);
        chk("un_seed", mac_o, 32'h0010_0000);
        start_i = 1'b1; mode_i = 2'b10; mac_i = 32'hDEAD; iter_i = 4'd0; in_vld_i = 1'b1;
        cyc(1);
        chk("un_step1", mac_o, 32'h0020_0000);
        chk("un_vld_busy", 32'(vld_o), 32'h0);
        start_i = 1'b0; in_vld_i = 1'b0; mode_i = 2'b00;
        cyc(1);
        chk("un_step2", mac_o, 32'h0040_0000);
        cyc(1);
        chk("un_step3", mac_o, 32'h0080_0000);
        chk("un_model3", m_acc, 32'h0080_0000);
        chk("un_done", 32'(done_o), 32'h1);
        chk("un_mode", 32'(mode_o), 32'h1);
        // start during done cycle is ignored; the following cycle it is accepted
        start_i = 1'b1; mode_i = 2'b11; iter_i = 4'd0; mac_i = 32'h0001_2345;
        cyc(1);
        chk("restart_ign", mac_o, 32'h0080_0000);
        cyc(1);
        start_i = 1'b0;
        chk("n0_mac", mac_o, 32'h0001_2345);
        chk("n0_done", 32'(done_o), 32'h1);
        cyc(2);

        // Saturation, positive then negative
        start_op(2'b11, 4'd1, 32'h7FFF_FFFF, 16'h0400, 32'h0);
        cyc(1);
        chk("sat_pos", mac_o, 32'h01FF_FC00);
        chk("sat_flag", 32'(sat_o), 32'h1);
        cyc(2);
        chk("sat_sticky", 32'(sat_o), 32'h1);
        start_op(2'b10, 4'd1, 32'h8000_0000, 16'h0400, 32'h0);
        cyc(1);
        chk("sat_neg", mac_o, 32'hFE00_0000);
        cyc(1);

        // Rounding vs truncation of 1.5
        start_op(2'b01, 4'd1, 32'h0000_0600, 16'h0400, 32'h0);
        chk("sat_clear", 32'(sat_o), 32'h0);
        cyc(1);
`ifdef PE_ROUND_EN
        chk("round", mac_o, 32'h0000_0800);
`else
        chk("trunc", mac_o, 32'h0000_0400);
`endif
        cyc(1);

        // Two steps, negative scale, offset changes between steps
        start_op(2'b10, 4'd2, 32'h0010_0000, 16'h0000, 32'h0);
        scale_i = 16'hFC00; offset_i = 32'h100;
        cyc(1);
        chk("neg_step1", mac_o, 32'hFFF0_0100);
        offset_i = 32'h200;
        cyc(1);
        chk("neg_step2", mac_o, 32'h0010_0200);
        cyc(2);

        // Reset in the middle of a run
        start_op(2'b01, 4'd5, 32'h0010_0000, 16'h0800, 32'h0);
        cyc(1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_run_busy", 32'(busy_o), 32'h0);
        chk("rst_run_mac", mac_o, 32'h0);
        chk("rst_run_mode", 32'(mode_o), 32'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(6);
        start_op(2'b01, 4'd1, 32'h0010_0000, 16'h0800, 32'h0);
        cyc(1);
        chk("post_rst", mac_o, 32'h0020_0000);
        chk("post_rst_done", 32'(done_o), 32'h1);
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
